// File: rtl/mygo_chan_pkg.sv
// Shared definitions for the mygo channel merge block.
// Provides the source-index width helper, stats counter width, and output register state.
package mygo_chan_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // clog2 with a floor of 1 so a single-channel build still has a 1-bit index.
  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mygo_chan_merge_if.sv
// Handshake bundle for the channel merger: N valid/ready inputs and one tagged output.
// The merger uses the slave modport; the producer/consumer side uses master.
interface mygo_chan_merge_if
  import mygo_chan_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int DATA_W = 32
);
  localparam int SRC_W = src_w(N_IN);

  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  logic [SRC_W-1:0]       out_src;
  logic                   out_valid;
  logic                   out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

endinterface

// File: rtl/mygo_rr_arbiter.sv
// Combinational N-way round-robin picker: first requester at or after ptr wins.
// The pointer itself is owned by the parent.
module mygo_rr_arbiter
  import mygo_chan_pkg::*;
#(
  parameter  int N_IN  = 2,
  localparam int SRC_W = src_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_IN-1:0]  gnt,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 0; off < N_IN; off++) begin
      idx = (int'(ptr) + off) % N_IN;
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SRC_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mygo_chan_merge.sv
// Fair fan-in merger: N valid/ready channels into one registered, source-tagged output.
// Define MYGO_MERGE_STATS_EN to add per-channel saturating grant counters (grant_count).
module mygo_chan_merge
  import mygo_chan_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int DATA_W = 32,
  localparam int SRC_W  = src_w(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  mygo_chan_merge_if.slave      bus
`ifdef MYGO_MERGE_STATS_EN
  ,
  output logic [N_IN*STAT_W-1:0] grant_count
`endif
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [SRC_W-1:0]  src_q,   src_d;
  logic [SRC_W-1:0]  rr_q,    rr_d;

  logic [N_IN-1:0]   arb_gnt;
  logic [SRC_W-1:0]  arb_idx;
  logic              arb_any;
  logic              can_load;
  logic              load;

  mygo_rr_arbiter #(.N_IN(N_IN)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    can_load     = (state_q == OUT_EMPTY) || bus.out_ready;
    load         = arb_any && can_load && !rst;
    bus.in_ready = load ? arb_gnt : '0;

    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (load) begin
      state_d = OUT_FULL;
      data_d  = bus.in_data[int'(arb_idx)*DATA_W +: DATA_W];
      src_d   = arb_idx;
      rr_d    = SRC_W'((int'(arb_idx) + 1) % N_IN);
    end else if (bus.out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the data register is reset too, since out_data must read 0 straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef MYGO_MERGE_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_IN];
  logic [STAT_W-1:0] cnt_d [N_IN];

  // Counters saturate rather than wrap so a long run never under-reports a busy channel.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.in_ready[i] && bus.in_valid[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_cnt
    assign grant_count[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule

// File: doc/mygo_chan_merge.md
Name: mygo_chan_merge

Overview:
- Fan-in channel merger for compiled CSP processes: N valid/ready input channels into one output channel.
- Counterpart of the per-destination router fan-out; implements a fair multi-sender `select` receive.
- Sits between the `mygo_fifo_*` read sides of N channels and the write side of one downstream FIFO or consumer process.
- Each output word is tagged with the index of its source channel.

Parameters:
- N_IN, 2, number of input channels (2..8).
- DATA_W, 32, payload width in bits.
- SRC_W, max(1, $clog2(N_IN)), width of the source index (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_IN*DATA_W  flattened payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  N_IN  per-channel valid.
- in_ready  output  N_IN  per-channel ready (one-hot or zero).
- out_data  output  DATA_W  merged payload.
- out_src  output  SRC_W  index of the channel that supplied out_data.
- out_valid  output  1  output word held.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (async assert, sync release to clk): out_valid=0, out_data=0, out_src=0, rr_ptr=0, grant counters (if enabled)=0. in_ready is 0 while rst=1.
- State: one output register (EMPTY when out_valid=0, FULL when out_valid=1) plus rr_ptr[SRC_W-1:0].
- can_load = !out_valid || out_ready. Pass-through: a drain and a load in the same cycle are allowed.
- Arbitration (combinational): scan channels rr_ptr, rr_ptr+1, … mod N_IN. The first one with in_valid=1 is the winner k.
- in_ready[k] = can_load. All other in_ready bits are 0. If no input is valid, in_ready is all zeros.
- Transfer on in_valid[k] && in_ready[k]:
  - next cycle out_data = in_data[k], out_src = k, out_valid = 1;
  - rr_ptr <= (k+1) mod N_IN.
- Output handshake: a word leaves on out_valid && out_ready. If no new load occurs in that cycle, out_valid <= 0.
- out_data and out_src stay stable while out_valid=1 && out_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word per cycle with out_ready held high.
- Fairness: with all inputs continuously valid, grants rotate 0,1,…,N_IN-1,0,…
- rr_ptr changes only on a transfer. An idle cycle does not advance it.
- Backpressure: while out_valid=1 and out_ready=0, every in_ready is 0 and no input is consumed. Input valids may come and go freely.
- An input may drop in_valid without a handshake. The block keeps no per-input state, so arbitration simply re-evaluates each cycle.
- Reset mid-operation: any held output word is discarded and rr_ptr returns to 0.
- N_IN=1: rr_ptr is constant 0 and the block degenerates to a 1-deep pipeline register.

Optional Feature:
- Macro: MYGO_MERGE_STATS_EN.
- With the macro defined: an extra output port grant_count, N_IN*16 bits, holds per-channel 16-bit transfer counters.
  - Counter i increments on each input-side transfer from channel i.
  - Counters saturate at 16'hFFFF and clear on rst.
- Without the macro: the port and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package mygo_chan_pkg holds:
  - the localparam function for SRC_W (clog2 with minimum 1);
  - STAT_W=16.
- One sub-module is natural: mygo_rr_arbiter, an N-way round-robin priority picker.
  - Inputs: req[N_IN], ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Purely combinational; rr_ptr update logic stays in the parent.

Test Plan:
- Reset/idle: assert rst mid-run while out_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0 during reset. First post-reset grant goes to channel 0.
- Single sender: ch1 sends 32'h11, 32'h22 back-to-back with out_ready=1 → out words 11, 22 with out_src=1 on consecutive cycles, each 1 cycle after its input handshake.
- Fairness (N_IN=4): all valid continuously, ch i sends 32'h100*i+seq → out_src sequence 0,1,2,3,0,1,2,3. No channel is granted twice before all others.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 (word 32'hA5) → out_data stays A5 and in_ready=0 throughout. Releasing out_ready drains A5 and loads the next winner in the same cycle.
- Pointer hold: ch0 transfers, then 3 idle cycles, then ch0 and ch1 valid together → ch1 is granted first (rr_ptr=1 retained).
- Stats (MYGO_MERGE_STATS_EN, N_IN=2): 3 transfers from ch0 and 5 from ch1 → grant_count = {16'd5, 16'd3}.
